// File: rtl/controlador_pkg.sv
// Shared constants for controlador_animacao: estado one-hot codes, per-state
// frame tables, status-bar byte codes and the sprite image content.
package controlador_pkg;

    localparam logic [3:0] ESTADO_IDLE       = 4'b0000;
    localparam logic [3:0] ESTADO_DORMINDO   = 4'b0001;
    localparam logic [3:0] ESTADO_COMENDO    = 4'b0010;
    localparam logic [3:0] ESTADO_DANDO_AULA = 4'b0100;
    localparam logic [3:0] ESTADO_MORTO      = 4'b1000;

    localparam logic [7:0] BAR_FULL      = 8'hEE;
    localparam logic [7:0] BAR_HALF      = 8'hE0;
    localparam logic [7:0] BAR_OFF       = 8'h00;
    localparam logic [7:0] BAR_LEVEL_MAX = 8'd100;

    localparam int unsigned BAR_ROWS      = 5;
    localparam int unsigned BAR_COL_FIRST = 1;
    localparam int unsigned BAR_COL_LAST  = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DORMINDO,
        ST_COMENDO,
        ST_DANDO_AULA,
        ST_MORTO
    } anim_state_t;

    function automatic anim_state_t decode_estado(input logic [3:0] estado);
        anim_state_t s;
        case (estado)
            ESTADO_IDLE:       s = ST_IDLE;
            ESTADO_DORMINDO:   s = ST_DORMINDO;
            ESTADO_COMENDO:    s = ST_COMENDO;
            ESTADO_DANDO_AULA: s = ST_DANDO_AULA;
            ESTADO_MORTO:      s = ST_MORTO;
            default:           s = ST_IDLE;
        endcase
        return s;
    endfunction

    function automatic int unsigned frame_count(input anim_state_t s);
        int unsigned n;
        case (s)
            ST_DORMINDO:   n = 4;
            ST_COMENDO:    n = 5;
            ST_DANDO_AULA: n = 7;
            ST_MORTO:      n = 8;
            default:       n = 6;
        endcase
        return n;
    endfunction

    // First frame of each state inside the concatenated sprite sheet.
    function automatic int unsigned frame_base(input anim_state_t s);
        int unsigned n;
        case (s)
            ST_DORMINDO:   n = 6;
            ST_COMENDO:    n = 10;
            ST_DANDO_AULA: n = 15;
            ST_MORTO:      n = 22;
            default:       n = 0;
        endcase
        return n;
    endfunction

    function automatic logic is_one_shot(input anim_state_t s);
        return s == ST_MORTO;
    endfunction

    // Sprite sheet content, indexed by global frame number and byte offset.
    function automatic logic [7:0] image_byte(input int unsigned frame_g, input int unsigned offset);
        return 8'((frame_g * 37) ^ offset ^ (offset >> 8));
    endfunction

endpackage

// File: rtl/barra_status.sv
// Status-bar cell renderer: maps a bar level (0..100, clamped) and a bar
// column (1..5) to the full/half/empty display byte.
module barra_status
    import controlador_pkg::*;
(
    input  logic [7:0] level,
    input  logic [2:0] col,
    output logic [7:0] bar_byte
);

    logic [7:0] lvl;
    logic [7:0] full_thr;
    logic [7:0] half_thr;

    always_comb begin
        lvl = (level > BAR_LEVEL_MAX) ? BAR_LEVEL_MAX : level;
        case (col)
            3'd1:    full_thr = 8'd90;
            3'd2:    full_thr = 8'd70;
            3'd3:    full_thr = 8'd50;
            3'd4:    full_thr = 8'd30;
            3'd5:    full_thr = 8'd10;
            default: full_thr = 8'hFF;
        endcase
        half_thr = full_thr - 8'd10;
        if (lvl > full_thr) begin
            bar_byte = BAR_FULL;
        end else if (lvl > half_thr) begin
            bar_byte = BAR_HALF;
        end else begin
            bar_byte = BAR_OFF;
        end
    end

endmodule

// File: rtl/controlador_animacao.sv
// Animation controller: streams sprite bytes per request, advances frames only
// at frame boundaries, overlays status bars. Optional macro: BAR_BLINK_EN.
module controlador_animacao
    import controlador_pkg::*;
#(
    parameter int unsigned BYTES_PER_FRAME = 1024,
    parameter int unsigned ADDR_W          = 10,
    parameter int unsigned NUM_BARS        = 3,
    parameter int unsigned BAR_ROW0        = 8,
    parameter int unsigned BAR_PITCH       = 10,
    parameter int unsigned TICK_DIV        = 2**20,
    parameter int unsigned MAX_FRAMES      = 8,
    localparam int unsigned FI_W           = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            estado,
    input  logic                  byte_req,
    input  logic [ADDR_W-1:0]     byte_counter,
    input  logic [NUM_BARS*8-1:0] bar_levels,
    output logic [7:0]            data_to_send,
    output logic                  data_valid,
    output logic [FI_W-1:0]       frame_idx,
    output logic                  anim_done
);

    localparam int unsigned       TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(BYTES_PER_FRAME - 1);

    anim_state_t       cur_state;
    anim_state_t       nxt_state;
    logic [FI_W-1:0]   st_last;
    logic [7:0]        st_base;
    logic              st_one_shot;

    logic [TW-1:0]     tick_cnt;
    logic [ADDR_W-1:0] idle_cnt;
    logic              pending;
    logic              tick_wrap;
    logic              boundary;
    logic              state_change;
    logic              advance;
    logic [FI_W-1:0]   adv_frame;
    logic              adv_done;

    logic              bar_hit;
    logic [7:0]        bar_level;
    logic [7:0]        bar_byte;
    logic [7:0]        bar_shown;
    logic [7:0]        rom_byte;
    logic [31:0]       row_u;
    logic [31:0]       col_u;

    // idle_cnt holds prior consecutive request-free cycles, saturating, so a
    // long gap keeps presenting a boundary every cycle.
    assign tick_wrap    = (tick_cnt == TICK_LAST);
    assign boundary     = byte_req ? (byte_counter == LAST_BYTE) : (idle_cnt == LAST_BYTE);
    assign state_change = (nxt_state != cur_state);
    assign advance      = boundary && (pending || tick_wrap);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        if (boundary) begin
            nxt_state = decode_estado(estado);
        end
    end

    always_comb begin
        st_last     = FI_W'(frame_count(cur_state) - 1);
        st_base     = 8'(frame_base(cur_state));
        st_one_shot = is_one_shot(cur_state);
    end

    always_comb begin
        if (frame_idx == st_last) begin
            adv_frame = st_one_shot ? st_last : '0;
        end else begin
            adv_frame = frame_idx + FI_W'(1);
        end
        adv_done = st_one_shot && (adv_frame == st_last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            idle_cnt <= '0;
        end else begin
            tick_cnt <= tick_wrap ? '0 : tick_cnt + TW'(1);
            if (byte_req) begin
                idle_cnt <= '0;
            end else if (idle_cnt != LAST_BYTE) begin
                idle_cnt <= idle_cnt + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_idx <= '0;
            anim_done <= 1'b0;
            pending   <= 1'b0;
        end else if (state_change) begin
            frame_idx <= '0;
            anim_done <= 1'b0;
            pending   <= 1'b0;
        end else if (advance) begin
            frame_idx <= adv_frame;
            anim_done <= adv_done;
            pending   <= 1'b0;
        end else if (tick_wrap) begin
            pending <= 1'b1;
        end
    end

    // Scan bars from highest to lowest index so the lowest overlapping bar wins.
    always_comb begin
        bar_hit   = 1'b0;
        bar_level = '0;
        row_u     = 32'(byte_counter[ADDR_W-1:3]);
        col_u     = 32'(byte_counter[2:0]);
        for (int unsigned i = 0; i < NUM_BARS; i++) begin
            if (row_u >= BAR_ROW0 + (NUM_BARS - 1 - i) * BAR_PITCH &&
                row_u <  BAR_ROW0 + (NUM_BARS - 1 - i) * BAR_PITCH + BAR_ROWS &&
                col_u >= BAR_COL_FIRST && col_u <= BAR_COL_LAST) begin
                bar_hit   = 1'b1;
                bar_level = bar_levels[8*(NUM_BARS-1-i) +: 8];
            end
        end
    end

    barra_status u_barra (
        .level    (bar_level),
        .col      (byte_counter[2:0]),
        .bar_byte (bar_byte)
    );

`ifdef BAR_BLINK_EN
    logic blink_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_phase <= 1'b0;
        end else if (tick_wrap) begin
            blink_phase <= ~blink_phase;
        end
    end

    assign bar_shown = (blink_phase && (bar_level < 8'd20)) ? BAR_OFF : bar_byte;
`else
    assign bar_shown = bar_byte;
`endif

    assign rom_byte = image_byte(32'(st_base) + 32'(frame_idx), 32'(byte_counter));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_to_send <= '0;
            data_valid   <= 1'b0;
        end else begin
            data_valid <= byte_req;
            if (byte_req) begin
                data_to_send <= bar_hit ? bar_shown : rom_byte;
            end
        end
    end

endmodule
